psum_accum_requant: RTL and testbench

Stage directly downstream of the 20-filter MAC array. Consumes each filter's 22-bit partial sum (one per input-channel tile, with its valid strobe) and accumulates the tiles per filter on top of a bias. After the configured tile count it rounds, shifts, applies ReLU and saturates each filter to 8 bits. It then presents all filters as one packed word to the next layer over a valid/ready handshake.

---
 rtl/psum_pkg.sv | 35 +++
 rtl/psum_accum_requant_lane.sv | 32 +++
 rtl/psum_accum_requant.sv | 133 +++++++++++++
 tb/tb_psum_accum_requant.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_pkg.sv
// Shared definitions for the partial-sum accumulate / requantize stage.
//   NUM_F   : number of filters (parallel lanes)
//   PSUM_W  : signed partial-sum width per lane from the MAC array
//   BIAS_W  : signed bias width per lane
//   ACC_W   : signed accumulator width per lane
//   TILE_W  : width of the tile-count configuration
//   state_t : controller states
//   sat_u8  : ReLU + saturate a signed accumulator-width value to 0..255
package psum_pkg;

  localparam int NUM_F  = 20;
  localparam int PSUM_W = 22;
  localparam int BIAS_W = 16;
  localparam int ACC_W  = 32;
  localparam int TILE_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    QUANT = 2'd2,
    OUT   = 2'd3
  } state_t;

  function automatic logic [7:0] sat_u8(input logic signed [ACC_W-1:0] r);
    logic [7:0] res;
    if (r < 0)
      res = 8'd0;
    else if (r > 255)
      res = 8'hff;
    else
      res = r[7:0];
    return res;
  endfunction

endpackage

// File: rtl/psum_accum_requant_lane.sv
// Combinational requantizer for one lane.
//   acc   : signed accumulator value
//   shift : arithmetic right shift amount (0..31)
//   q     : unsigned 8-bit result after round-half-up, shift, ReLU, saturate
module psum_lane_requant
  import psum_pkg::*;
(
  input  logic signed [ACC_W-1:0] acc,
  input  logic        [4:0]       shift,
  output logic        [7:0]       q
);

  // One guard bit so adding the rounding constant can never wrap.
  logic signed [ACC_W:0]   acc_x;
  logic signed [ACC_W:0]   half;
  logic signed [ACC_W:0]   sum;
  logic signed [ACC_W:0]   shifted;
  logic signed [ACC_W-1:0] r;

  always_comb begin
    acc_x = {acc[ACC_W-1], acc};
    half  = '0;
    if (shift != 5'd0)
      half[shift - 5'd1] = 1'b1;
    sum     = acc_x + half;
    shifted = sum >>> shift;
    // With shift >= 1 the shifted value always fits back in ACC_W bits.
    r = (shift == 5'd0) ? acc : shifted[ACC_W-1:0];
    q = sat_u8(r);
  end

endmodule

// File: rtl/psum_accum_requant.sv
// Per-filter partial-sum accumulator with requantization to 8 bits.
//   clk, rst      : clock, synchronous active-high reset
//   start_i       : begin a pixel (IDLE only); latches cfg_* and bias_i
//   cfg_tiles_i   : psum tiles per filter for this pixel (0 = bias only)
//   cfg_shift_i   : requantization right shift
//   bias_i        : packed signed biases, lane f at [f*BIAS_W +: BIAS_W]
//   vld_i, psum_i : per-lane psum strobes / packed signed partial sums
//   q_o, vld_o    : packed 8-bit results and their valid
//   rdy_i         : downstream ready
//   busy_o        : controller not in IDLE
//   done_o        : one-cycle pulse on the output handshake
//   err_o         : sticky; a strobe arrived on a full lane or outside ACC
//   dbg_state_o   : current controller state (state_t encoding)
//
// Output handshake: a word transfers on a rising edge where vld_o and rdy_i
// are both high. Once raised, vld_o stays high and q_o stays unchanged until
// that transfer happens; vld_o never drops without a transfer.
module psum_accum_requant
  import psum_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start_i,
  input  logic [TILE_W-1:0]        cfg_tiles_i,
  input  logic [4:0]               cfg_shift_i,
  input  logic [NUM_F*BIAS_W-1:0]  bias_i,
  input  logic [NUM_F-1:0]         vld_i,
  input  logic [NUM_F*PSUM_W-1:0]  psum_i,
  output logic [NUM_F*8-1:0]       q_o,
  output logic                     vld_o,
  input  logic                     rdy_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o,
  output logic [1:0]               dbg_state_o
);

  state_t                  state, state_nx;
  logic signed [ACC_W-1:0] acc [NUM_F];
  logic [TILE_W-1:0]       cnt [NUM_F];
  logic [TILE_W-1:0]       tiles_q;
  logic [4:0]              shift_q;
  logic [NUM_F-1:0]        take;
  logic [NUM_F-1:0]        full_nx;
  logic [NUM_F*8-1:0]      q_lanes;

  // A strobe is accepted only in ACC on a lane that still needs tiles;
  // full_nx includes this cycle's acceptance so QUANT follows immediately.
  always_comb begin
    take    = '0;
    full_nx = '0;
    for (int f = 0; f < NUM_F; f++) begin
      take[f]    = (state == ACC) && vld_i[f] && (cnt[f] < tiles_q);
      full_nx[f] = ((cnt[f] + {{(TILE_W-1){1'b0}}, take[f]}) == tiles_q);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:  if (start_i) state_nx = (cfg_tiles_i == '0) ? QUANT : ACC;
      ACC:   if (&full_nx) state_nx = QUANT;
      QUANT: state_nx = OUT;
      OUT:   if (vld_o && rdy_i) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      q_o     <= '0;
      vld_o   <= 1'b0;
      done_o  <= 1'b0;
      err_o   <= 1'b0;
      tiles_q <= '0;
      shift_q <= '0;
      for (int f = 0; f < NUM_F; f++) begin
        acc[f] <= '0;
        cnt[f] <= '0;
      end
    end else begin
      state  <= state_nx;
      done_o <= 1'b0;
      // Any strobe not accepted is dropped and flagged.
      if (|(vld_i & ~take))
        err_o <= 1'b1;
      case (state)
        IDLE: begin
          if (start_i) begin
            tiles_q <= cfg_tiles_i;
            shift_q <= cfg_shift_i;
            for (int f = 0; f < NUM_F; f++) begin
              acc[f] <= ACC_W'($signed(bias_i[f*BIAS_W +: BIAS_W]));
              cnt[f] <= '0;
            end
          end
        end
        ACC: begin
          for (int f = 0; f < NUM_F; f++) begin
            if (take[f]) begin
              acc[f] <= acc[f] + ACC_W'($signed(psum_i[f*PSUM_W +: PSUM_W]));
              cnt[f] <= cnt[f] + 1'b1;
            end
          end
        end
        QUANT: begin
          q_o   <= q_lanes;
          vld_o <= 1'b1;
        end
        OUT: begin
          if (vld_o && rdy_i) begin
            vld_o  <= 1'b0;
            done_o <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar g = 0; g < NUM_F; g++) begin : g_lane
    psum_lane_requant u_lane (
      .acc   (acc[g]),
      .shift (shift_q),
      .q     (q_lanes[g*8 +: 8])
    );
  end

  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_psum_accum_requant.sv
module tb_psum_accum_requant;
  import psum_pkg::*;

  localparam int QW = NUM_F*8;

  // ---------------- clock / reset / DUT ----------------
  logic                    clk = 1'b0;
  logic                    rst;
  logic                    start_i;
  logic [TILE_W-1:0]       cfg_tiles_i;
  logic [4:0]              cfg_shift_i;
  logic [NUM_F*BIAS_W-1:0] bias_i;
  logic [NUM_F-1:0]        vld_i;
  logic [NUM_F*PSUM_W-1:0] psum_i;
  logic [QW-1:0]           q_o;
  logic                    vld_o, rdy_i, busy_o, done_o, err_o;
  logic [1:0]              dbg_state_o;

  always #5 clk = ~clk;

  psum_accum_requant dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_tiles_i(cfg_tiles_i),
    .cfg_shift_i(cfg_shift_i), .bias_i(bias_i), .vld_i(vld_i), .psum_i(psum_i),
    .q_o(q_o), .vld_o(vld_o), .rdy_i(rdy_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o), .dbg_state_o(dbg_state_o)
  );

  // ---------------- scoreboard / bench model ----------------
  int            checks = 0;
  int            failures = 0;
  logic [QW-1:0] exp_q[$];
  logic [QW-1:0] last_q;
  logic [QW-1:0] held_q;
  logic [QW-1:0] w;
  longint        m_acc[NUM_F];
  int            m_cnt[NUM_F];
  int            m_psum[NUM_F];
  int            m_tiles, m_shift;
  logic [NUM_F*BIAS_W-1:0] bias_v;
  logic [NUM_F*PSUM_W-1:0] psum_v;

  typedef struct {
    int tiles; int shift; int bias0; int bias_step;
    int psum0; int psum_step; int exp0;
  } vec_t;
  vec_t vecs[12];

  task automatic check_w(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Round half up via explicit floor division, then clamp to 0..255.
  function automatic logic [7:0] model_q(input longint a, input int sh);
    longint den, num, r;
    if (sh == 0) r = a;
    else begin
      den = longint'(1) << sh;
      num = a + den / 2;
      if (num >= 0) r = num / den;
      else r = -((-num + den - 1) / den);
    end
    if (r < 0) return 8'd0;
    if (r > 255) return 8'd255;
    return r[7:0];
  endfunction

  function automatic logic [QW-1:0] model_word();
    logic [QW-1:0] res;
    for (int f = 0; f < NUM_F; f++) res[f*8 +: 8] = model_q(m_acc[f], m_shift);
    return res;
  endfunction

  function automatic bit all_full();
    for (int f = 0; f < NUM_F; f++) if (m_cnt[f] < m_tiles) return 1'b0;
    return 1'b1;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start_i = 1'b0; cfg_tiles_i = '0; cfg_shift_i = '0; bias_i = '0;
    vld_i = '0; psum_i = '0; rdy_i = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    step(); step();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_bias(input int f, input int b);
    bias_v[f*BIAS_W +: BIAS_W] = BIAS_W'(b);
    m_acc[f] = b;
    m_cnt[f] = 0;
  endtask

  task automatic set_psum(input int f, input int v);
    psum_v[f*PSUM_W +: PSUM_W] = PSUM_W'(v);
    m_psum[f] = v;
  endtask

  task automatic start_px(input int tiles, input int sh);
    cfg_tiles_i = TILE_W'(tiles);
    cfg_shift_i = 5'(sh);
    bias_i = bias_v;
    m_tiles = tiles;
    m_shift = sh;
    start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic psum_cycle(input logic [NUM_F-1:0] mask);
    for (int f = 0; f < NUM_F; f++) begin
      if (mask[f] && m_cnt[f] < m_tiles) begin
        m_acc[f] += m_psum[f];
        m_cnt[f]++;
      end
    end
    vld_i = mask;
    psum_i = psum_v;
    step();
    vld_i = '0;
  endtask

  // Pop and compare on the handshake; the following cycle must show done_o.
  task automatic wait_out(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (vld_o && rdy_i) begin
        last_q = q_o;
        if (exp_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL %s: unexpected output %h", tag, q_o);
        end else begin
          check_w({tag, " q_o"}, q_o, exp_q.pop_front());
        end
        step();
        check1({tag, " done_o"}, done_o, 1'b1);
        return;
      end
      step();
    end
    checks++; failures++;
    $display("FAIL %s: timeout waiting for vld_o", tag);
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    logic [NUM_F-1:0] mask;
    int guard;
    rst = 1'b1;
    idle_inputs();
    bias_v = '0; psum_v = '0;
    step(); step(); step();

    // Reset state
    check_w("rst q_o", q_o, '0);
    check1("rst vld_o", vld_o, 1'b0);
    check1("rst done_o", done_o, 1'b0);
    check1("rst err_o", err_o, 1'b0);
    check1("rst busy_o", busy_o, 1'b0);
    check_w("rst state", QW'(dbg_state_o), QW'(IDLE));
    rst = 1'b0;
    step();

    // Basic: tiles=2, lane0 10+20, other lanes 1+1
    for (int f = 0; f < NUM_F; f++) begin set_bias(f, 0); set_psum(f, 1); end
    start_px(2, 0);
    check_w("basic state acc", QW'(dbg_state_o), QW'(ACC));
    set_psum(0, 10);
    psum_cycle('1);
    set_psum(0, 20);
    psum_cycle('1);
    check_w("basic state quant", QW'(dbg_state_o), QW'(QUANT));
    check1("basic vld_o early", vld_o, 1'b0);
    w = {{(NUM_F-1){8'd2}}, 8'd30};
    exp_q.push_back(w);
    step();
    check1("basic vld_o", vld_o, 1'b1);
    wait_out("basic");
    check1("basic busy after", busy_o, 1'b0);
    step();
    check1("basic done pulse", done_o, 1'b0);
    check1("basic err", err_o, 1'b0);

    // Strobe while IDLE is flagged
    vld_i = '1;
    step();
    vld_i = '0;
    check1("idle strobe err", err_o, 1'b1);
    check1("idle strobe busy", busy_o, 1'b0);
    do_reset();
    check1("err cleared by rst", err_o, 1'b0);

    // Table-driven uniform pixels
    vecs[0]  = '{1, 4, 8, 0, 40, 0, 3};
    vecs[1]  = '{2, 0, 0, 0, 10, 1, 20};
    vecs[2]  = '{1, 0, 0, 0, -500, 0, 0};
    vecs[3]  = '{1, 0, 0, 0, 10000, 0, 255};
    vecs[4]  = '{3, 2, -4, 3, 5, -2, 3};
    vecs[5]  = '{1, 1, 0, 0, 5, 0, 3};
    vecs[6]  = '{1, 1, 0, 0, -3, 0, 0};
    vecs[7]  = '{4, 31, 0, 0, 2097151, 0, 0};
    vecs[8]  = '{200, 8, -32768, 0, 2097151, 0, 255};
    vecs[9]  = '{1, 3, 0, 0, 2044, -8, 255};
    vecs[10] = '{1, 3, 100, 0, 1900, 0, 250};
    vecs[11] = '{2, 0, -32768, 0, -2097152, 0, 0};
    for (int i = 0; i < 12; i++) begin
      for (int f = 0; f < NUM_F; f++) begin
        set_bias(f, vecs[i].bias0 + f * vecs[i].bias_step);
        set_psum(f, vecs[i].psum0 + f * vecs[i].psum_step);
      end
      start_px(vecs[i].tiles, vecs[i].shift);
      for (int t = 0; t < vecs[i].tiles; t++) psum_cycle('1);
      exp_q.push_back(model_word());
      wait_out($sformatf("vec%0d", i));
      check_w($sformatf("vec%0d lane0", i), QW'(last_q[7:0]), QW'(vecs[i].exp0));
    end
    check1("table err", err_o, 1'b0);

    // Staggered lanes, tiles=3, with an extra strobe on lane 3
    for (int f = 0; f < NUM_F; f++) begin set_bias(f, 0); set_psum(f, f + 1); end
    start_px(3, 0);
    psum_cycle(20'h003FF);
    psum_cycle(20'hFFFFF);
    psum_cycle(20'hFFFFF);
    check_w("stag state c2", QW'(dbg_state_o), QW'(ACC));
    check1("stag err c2", err_o, 1'b0);
    set_psum(3, 1000);
    psum_cycle(20'h00008);
    set_psum(3, 4);
    check1("stag err extra", err_o, 1'b1);
    check_w("stag state c3", QW'(dbg_state_o), QW'(ACC));
    psum_cycle(20'hFFC00);
    exp_q.push_back(model_word());
    wait_out("stag");
    check_w("stag lane3", QW'(last_q[3*8 +: 8]), QW'(12));
    do_reset();

    // Backpressure: hold rdy_i low, start_i during OUT ignored
    for (int f = 0; f < NUM_F; f++) begin set_bias(f, f); set_psum(f, 2 * f); end
    start_px(1, 0);
    rdy_i = 1'b0;
    psum_cycle('1);
    exp_q.push_back(model_word());
    step();
    check1("bp vld_o", vld_o, 1'b1);
    held_q = q_o;
    check_w("bp q first", held_q, exp_q[0]);
    for (int i = 0; i < 6; i++) begin
      start_i = (i == 2);
      step();
      start_i = 1'b0;
      check_w($sformatf("bp q stable %0d", i), q_o, held_q);
      check1($sformatf("bp vld %0d", i), vld_o, 1'b1);
      check1($sformatf("bp busy %0d", i), busy_o, 1'b1);
      check1($sformatf("bp done %0d", i), done_o, 1'b0);
    end
    check_w("bp state out", QW'(dbg_state_o), QW'(OUT));
    rdy_i = 1'b1;
    wait_out("bp");
    check_w("bp state idle", QW'(dbg_state_o), QW'(IDLE));
    step();
    check1("bp single done", done_o, 1'b0);
    check1("bp no restart", busy_o, 1'b0);
    check1("bp err", err_o, 1'b0);

    // tiles=0: bias-only result two cycles after start
    for (int f = 0; f < NUM_F; f++) set_bias(f, f * 3);
    start_px(0, 0);
    check_w("t0 state quant", QW'(dbg_state_o), QW'(QUANT));
    check1("t0 vld early", vld_o, 1'b0);
    for (int f = 0; f < NUM_F; f++) w[f*8 +: 8] = 8'(f * 3);
    exp_q.push_back(w);
    step();
    check1("t0 vld_o", vld_o, 1'b1);
    wait_out("t0");

    // Reset mid-ACC, then a clean pixel
    for (int f = 0; f < NUM_F; f++) begin set_bias(f, 5); set_psum(f, 7); end
    start_px(2, 0);
    psum_cycle('1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check1("mid rst vld", vld_o, 1'b0);
    check_w("mid rst q", q_o, '0);
    check1("mid rst err", err_o, 1'b0);
    check_w("mid rst state", QW'(dbg_state_o), QW'(IDLE));
    for (int f = 0; f < NUM_F; f++) begin set_bias(f, 1); set_psum(f, 2); end
    start_px(2, 0);
    psum_cycle('1);
    psum_cycle('1);
    exp_q.push_back(model_word());
    wait_out("fresh");
    check_w("fresh lane0", QW'(last_q[7:0]), QW'(5));

    // Random pixels with random per-lane strobe patterns
    for (int p = 0; p < 4; p++) begin
      for (int f = 0; f < NUM_F; f++) set_bias(f, int'($urandom_range(0, 2000)) - 1000);
      start_px(int'($urandom_range(1, 4)), int'($urandom_range(0, 6)));
      guard = 0;
      while (!all_full() && guard < 200) begin
        for (int f = 0; f < NUM_F; f++) begin
          set_psum(f, int'($urandom_range(0, 6000)) - 3000);
          mask[f] = (m_cnt[f] < m_tiles) && ($urandom_range(0, 1) == 1);
        end
        psum_cycle(mask);
        guard++;
      end
      if (guard >= 200) begin
        checks++; failures++;
        $display("FAIL rand%0d: stimulus guard expired", p);
      end
      exp_q.push_back(model_word());
      wait_out($sformatf("rand%0d", p));
    end
    check1("rand err", err_o, 1'b0);
    check_w("queue empty", QW'(exp_q.size()), '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
